otter_branch_predictor: RTL and testbench
=========================================

Name: otter_branch_predictor

Overview:
Parametrised branch target buffer with saturating-counter direction prediction for the pipelined OTTER core.
- Fetch side: looks up PC_F in the same cycle and supplies a predicted next PC, replacing the fixed PC+4 path.
- Execute side: accepts the resolved branch/jump outcome, trains the table and flags mispredictions with a redirect PC.
- Keeps saturating performance counters for lookups and mispredictions.

Parameters:
ENTRIES, 16, number of BTB entries; power of 2, at least 2; IDX = log2(ENTRIES).
CTR_BITS, 2, width of each direction counter; at least 1.
CNT_WIDTH, 32, width of each performance counter.

Ports:
CLK  in  1  system clock, rising edge.
RESET  in  1  synchronous, active-high reset.
LOOKUP_EN  in  1  fetch stage advancing; gates the lookup counter only.
PC_F  in  32  fetch PC.
PRED_TAKEN_F  out  1  predicted taken.
PRED_TARGET_F  out  32  predicted next PC.
UPD_VALID  in  1  a branch or jump resolved in execute this cycle.
UPD_PC  in  32  PC of the resolved instruction.
UPD_IS_JUMP  in  1  1 = jal/jalr, 0 = conditional branch.
UPD_TAKEN  in  1  actual direction.
UPD_TARGET  in  32  actual target address.
UPD_PRED_TAKEN  in  1  prediction carried down the pipeline with the instruction.
UPD_PRED_TARGET  in  32  predicted target carried down the pipeline.
FLUSH_ALL  in  1  invalidate every entry.
MISPREDICT_E  out  1  execute-stage misprediction.
REDIRECT_PC_E  out  32  correct next PC when MISPREDICT_E = 1.
LOOKUP_CNT  out  CNT_WIDTH  number of lookups.
MISPRED_CNT  out  CNT_WIDTH  number of mispredictions.

Behaviour:
- Clocking: one clock, CLK. RESET is synchronous and active-high.
- Entry fields: valid, tag = PC[31:IDX+2], target[31:0], ctr[CTR_BITS-1:0], is_jump.
- Indexing: index = PC[IDX+1:2]. The table is direct-mapped.
- Lookup (combinational from registered table state, 0-cycle latency):
  - hit = valid & tag match.
  - PRED_TAKEN_F = hit & (is_jump | ctr MSB).
  - PRED_TARGET_F = entry target when PRED_TAKEN_F = 1, else PC_F+4 (mod 2^32).
- Misprediction (combinational, asserted only when UPD_VALID = 1):
  - MISPREDICT_E = (UPD_PRED_TAKEN != UPD_TAKEN) | (UPD_TAKEN & UPD_PRED_TARGET != UPD_TARGET).
  - REDIRECT_PC_E = UPD_TAKEN ? UPD_TARGET : UPD_PC+4.
  - With UPD_VALID = 0: MISPREDICT_E = 0 and REDIRECT_PC_E = UPD_PC+4.
- Training (on the clock edge when UPD_VALID = 1; hit evaluated on UPD_PC):
  - Hit on a branch: ctr increments when taken, decrements when not taken, saturating at 2^CTR_BITS-1 and 0. Target is written only when taken.
  - Hit on a jump: ctr is set to maximum; target, tag and is_jump are rewritten.
  - Miss, taken: the entry is allocated or replaced: valid=1, tag, target, is_jump=UPD_IS_JUMP, ctr = 2^(CTR_BITS-1) (weakly taken), or maximum for a jump.
  - Miss, not taken: no table change.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update contents. The new contents are visible from the next cycle.
- FLUSH_ALL: all valid bits clear at the edge and the update in the same cycle is discarded. Performance counters are not affected.
- Performance counters:
  - LOOKUP_CNT increments on each edge with LOOKUP_EN = 1.
  - MISPRED_CNT increments on each edge with MISPREDICT_E = 1.
  - Both saturate at all-ones and do not wrap.
- RESET (takes priority over everything, including mid-update):
  - All valid bits, ctr values and both counters go to 0. is_jump values are don't-care.
  - Next cycle: PRED_TAKEN_F = 0, PRED_TARGET_F = PC_F+4, LOOKUP_CNT = MISPRED_CNT = 0.
  - With UPD_VALID = 0: MISPREDICT_E = 0.
- PC bits [1:0] are ignored for indexing and tag compare.

Test Plan:
1. After RESET, PC_F=0x100 -> PRED_TAKEN_F=0 and PRED_TARGET_F=0x104. PC_F=0xFFFFFFFC -> PRED_TARGET_F=0x00000000 (wrap).
2. Branch training at 0x200, target 0x180:
   - Taken update with UPD_PRED_TAKEN=0 -> MISPREDICT_E=1, REDIRECT_PC_E=0x180, MISPRED_CNT=1; next cycle PC_F=0x200 predicts taken with target 0x180 (ctr=2).
   - Two not-taken updates -> ctr=0, PC_F=0x200 predicts 0x204.
   - Four further taken updates -> ctr saturates at 3.
3. Aliasing (ENTRIES=16): entry at 0x200, then a taken update at 0x240 (same index) -> entry replaced; PC_F=0x200 misses, PC_F=0x240 hits.
4. Jump at 0x300 to 0x400, then an update at 0x300 taken with predicted target 0x500 but actual 0x404 -> MISPREDICT_E=1, REDIRECT_PC_E=0x404, stored target becomes 0x404.
5. Update and lookup at PC 0x200 in the same cycle -> old prediction returned that cycle, new one the next cycle. FLUSH_ALL asserted alongside an update -> table empty afterwards.
6. CNT_WIDTH=4, LOOKUP_EN held high for 20 cycles -> LOOKUP_CNT saturates at 15. RESET asserted during an update -> counters 0 and the entry is not allocated.

Source files
------------

// File: rtl/otter_branch_predictor_if.sv
// Fetch/execute/performance signal bundle for otter_branch_predictor.
//   master : pipeline side. Drives the fetch PC, the resolved-branch update
//            and the flush. Receives the prediction, the redirect and the counters.
//   slave  : predictor side. It uses the opposite directions.
// Signal names are the same as the predictor's external port names.
interface otter_branch_predictor_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 LOOKUP_EN;
  logic [31:0]          PC_F;
  logic                 PRED_TAKEN_F;
  logic [31:0]          PRED_TARGET_F;
  logic                 UPD_VALID;
  logic [31:0]          UPD_PC;
  logic                 UPD_IS_JUMP;
  logic                 UPD_TAKEN;
  logic [31:0]          UPD_TARGET;
  logic                 UPD_PRED_TAKEN;
  logic [31:0]          UPD_PRED_TARGET;
  logic                 FLUSH_ALL;
  logic                 MISPREDICT_E;
  logic [31:0]          REDIRECT_PC_E;
  logic [CNT_WIDTH-1:0] LOOKUP_CNT;
  logic [CNT_WIDTH-1:0] MISPRED_CNT;

  modport master (
    output LOOKUP_EN, PC_F, UPD_VALID, UPD_PC, UPD_IS_JUMP, UPD_TAKEN,
           UPD_TARGET, UPD_PRED_TAKEN, UPD_PRED_TARGET, FLUSH_ALL,
    input  PRED_TAKEN_F, PRED_TARGET_F, MISPREDICT_E, REDIRECT_PC_E,
           LOOKUP_CNT, MISPRED_CNT
  );

  modport slave (
    input  LOOKUP_EN, PC_F, UPD_VALID, UPD_PC, UPD_IS_JUMP, UPD_TAKEN,
           UPD_TARGET, UPD_PRED_TAKEN, UPD_PRED_TARGET, FLUSH_ALL,
    output PRED_TAKEN_F, PRED_TARGET_F, MISPREDICT_E, REDIRECT_PC_E,
           LOOKUP_CNT, MISPRED_CNT
  );
endinterface

// File: rtl/otter_branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
//   CLK   : rising-edge clock.
//   RESET : synchronous, active high. It clears valid bits, direction
//           counters and the performance counters.
//   bp    : slave side of otter_branch_predictor_if.
//           - Fetch side: PC_F is looked up combinationally, which gives
//             PRED_TAKEN_F and PRED_TARGET_F.
//           - Execute side: UPD_* trains the table. MISPREDICT_E and
//             REDIRECT_PC_E are driven combinationally.
//           - FLUSH_ALL invalidates every entry.
//           - LOOKUP_CNT and MISPRED_CNT are the saturating performance counters.
module otter_branch_predictor #(
  parameter int ENTRIES   = 16,
  parameter int CTR_BITS  = 2,
  parameter int CNT_WIDTH = 32
) (
  input logic CLK,
  input logic RESET,
  otter_branch_predictor_if.slave bp
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;
  localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0]  CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  // Read-side views of the per-entry storage. These are assembled from the
  // generate blocks below.
  logic [ENTRIES-1:0]  valid_vec;
  logic [ENTRIES-1:0]  is_jump_vec;
  logic [TAG_W-1:0]    tag_vec    [ENTRIES];
  logic [31:0]         target_vec [ENTRIES];
  logic [CTR_BITS-1:0] ctr_vec    [ENTRIES];

  // Fetch-side lookup. The read is combinational from registered state, so a
  // same-cycle update only becomes visible after the edge.
  logic [IDX-1:0]   f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic             f_taken;

  assign f_idx   = bp.PC_F[IDX+1:2];
  assign f_tag   = bp.PC_F[31:IDX+2];
  assign f_hit   = valid_vec[f_idx] && (tag_vec[f_idx] == f_tag);
  assign f_taken = f_hit && (is_jump_vec[f_idx] || ctr_vec[f_idx][CTR_BITS-1]);

  assign bp.PRED_TAKEN_F  = f_taken;
  assign bp.PRED_TARGET_F = f_taken ? target_vec[f_idx] : bp.PC_F + 32'd4;

  // Execute-side misprediction check.
  logic mispredict;

  assign mispredict = bp.UPD_VALID &&
                      ((bp.UPD_PRED_TAKEN != bp.UPD_TAKEN) ||
                       (bp.UPD_TAKEN && (bp.UPD_PRED_TARGET != bp.UPD_TARGET)));

  assign bp.MISPREDICT_E  = mispredict;
  assign bp.REDIRECT_PC_E = (bp.UPD_VALID && bp.UPD_TAKEN) ? bp.UPD_TARGET
                                                           : bp.UPD_PC + 32'd4;

  // Training decision. This logic computes the new contents of the single
  // entry that is addressed by UPD_PC.
  logic [IDX-1:0]      u_idx;
  logic [TAG_W-1:0]    u_tag;
  logic                u_hit;
  logic                wr_en;
  logic [31:0]         wr_target;
  logic [CTR_BITS-1:0] wr_ctr;
  logic                wr_jump;

  assign u_idx = bp.UPD_PC[IDX+1:2];
  assign u_tag = bp.UPD_PC[31:IDX+2];
  assign u_hit = valid_vec[u_idx] && (tag_vec[u_idx] == u_tag);

  always_comb begin
    wr_en     = 1'b0;
    wr_target = target_vec[u_idx];
    wr_ctr    = ctr_vec[u_idx];
    wr_jump   = is_jump_vec[u_idx];
    if (bp.UPD_VALID && !bp.FLUSH_ALL) begin
      if (u_hit && !bp.UPD_IS_JUMP) begin
        // The update is a conditional branch that hits an existing entry.
        // The direction counter moves one step and saturates at both ends.
        wr_en = 1'b1;
        if (bp.UPD_TAKEN) begin
          wr_target = bp.UPD_TARGET;
          if (ctr_vec[u_idx] != CTR_MAX) begin
            wr_ctr = ctr_vec[u_idx] + 1'b1;
          end
        end else if (ctr_vec[u_idx] != '0) begin
          wr_ctr = ctr_vec[u_idx] - 1'b1;
        end
      end else if (u_hit || bp.UPD_TAKEN) begin
        // This branch covers two cases: a jump that hits, and a taken
        // instruction that misses. Both cases rewrite the whole entry.
        wr_en     = 1'b1;
        wr_target = bp.UPD_TARGET;
        wr_jump   = bp.UPD_IS_JUMP;
        wr_ctr    = bp.UPD_IS_JUMP ? CTR_MAX : CTR_WEAK;
      end
    end
  end

  // Per-entry storage. Only valid and ctr are reset. A cleared valid bit
  // masks the other fields, so tag, target and is_jump need no reset.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic                valid_reg;
    logic                is_jump_reg;
    logic [TAG_W-1:0]    tag_reg;
    logic [31:0]         target_reg;
    logic [CTR_BITS-1:0] ctr_reg;

    always_ff @(posedge CLK) begin
      if (RESET) begin
        valid_reg <= 1'b0;
        ctr_reg   <= '0;
      end else if (bp.FLUSH_ALL) begin
        valid_reg <= 1'b0;
      end else if (wr_en && (u_idx == IDX'(gi))) begin
        valid_reg   <= 1'b1;
        tag_reg     <= u_tag;
        target_reg  <= wr_target;
        ctr_reg     <= wr_ctr;
        is_jump_reg <= wr_jump;
      end
    end

    assign valid_vec[gi]   = valid_reg;
    assign is_jump_vec[gi] = is_jump_reg;
    assign tag_vec[gi]     = tag_reg;
    assign target_vec[gi]  = target_reg;
    assign ctr_vec[gi]     = ctr_reg;
  end

  // Saturating performance counters. A flush does not affect them.
  logic [CNT_WIDTH-1:0] lookup_cnt_reg;
  logic [CNT_WIDTH-1:0] mispred_cnt_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      lookup_cnt_reg  <= '0;
      mispred_cnt_reg <= '0;
    end else begin
      if (bp.LOOKUP_EN && (lookup_cnt_reg != CNT_MAX)) begin
        lookup_cnt_reg <= lookup_cnt_reg + 1'b1;
      end
      if (mispredict && (mispred_cnt_reg != CNT_MAX)) begin
        mispred_cnt_reg <= mispred_cnt_reg + 1'b1;
      end
    end
  end

  assign bp.LOOKUP_CNT  = lookup_cnt_reg;
  assign bp.MISPRED_CNT = mispred_cnt_reg;
endmodule

// File: tb/tb_otter_branch_predictor.sv
// Self-checking bench for otter_branch_predictor.
// A behavioural table model predicts every output in every cycle. Directed
// scenarios add literal expectations. A randomized phase follows.
// A second instance with 4-bit counters shares the same stimulus, so that
// counter saturation can be observed.
module tb_otter_branch_predictor;
  localparam int ENTRIES = 16;
  localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX4  = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  otter_branch_predictor_if #(.CNT_WIDTH(32)) bus ();
  otter_branch_predictor_if #(.CNT_WIDTH(4))  bus4 ();

  assign bus4.LOOKUP_EN       = bus.LOOKUP_EN;
  assign bus4.PC_F            = bus.PC_F;
  assign bus4.UPD_VALID       = bus.UPD_VALID;
  assign bus4.UPD_PC          = bus.UPD_PC;
  assign bus4.UPD_IS_JUMP     = bus.UPD_IS_JUMP;
  assign bus4.UPD_TAKEN       = bus.UPD_TAKEN;
  assign bus4.UPD_TARGET      = bus.UPD_TARGET;
  assign bus4.UPD_PRED_TAKEN  = bus.UPD_PRED_TAKEN;
  assign bus4.UPD_PRED_TARGET = bus.UPD_PRED_TARGET;
  assign bus4.FLUSH_ALL       = bus.FLUSH_ALL;

  otter_branch_predictor #(.ENTRIES(ENTRIES), .CTR_BITS(2), .CNT_WIDTH(32)) dut (
    .CLK(clk), .RESET(rst), .bp(bus.slave)
  );
  otter_branch_predictor #(.ENTRIES(ENTRIES), .CTR_BITS(2), .CNT_WIDTH(4)) dut4 (
    .CLK(clk), .RESET(rst), .bp(bus4.slave)
  );

  // Behavioural model. Each slot remembers the full word address of the
  // instruction that owns it.
  typedef struct {
    bit        valid;
    bit [29:0] word;
    bit [31:0] target;
    int        ctr;
    bit        jump;
  } ent_t;

  ent_t   m [ENTRIES];
  longint m_lcnt, m_mcnt, m_lcnt4, m_mcnt4;
  int     vectors = 0;
  int     miscompares = 0;

  function automatic int slot(input logic [31:0] pc);
    return int'(pc >> 2) % ENTRIES;
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    int s = slot(pc);
    return m[s].valid && (m[s].word == pc[31:2]) && (m[s].jump || m[s].ctr >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_taken(pc) ? m[slot(pc)].target : pc + 32'd4;
  endfunction

  function automatic bit m_mis();
    if (!bus.UPD_VALID) return 1'b0;
    return (bus.UPD_PRED_TAKEN != bus.UPD_TAKEN) ||
           (bus.UPD_TAKEN && (bus.UPD_PRED_TARGET != bus.UPD_TARGET));
  endfunction

  function automatic logic [31:0] m_redirect();
    return (bus.UPD_VALID && bus.UPD_TAKEN) ? bus.UPD_TARGET : bus.UPD_PC + 32'd4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process. It checks every DUT output against the model.
  task automatic compare_all();
    chk("pred_taken",   32'(bus.PRED_TAKEN_F),  32'(m_taken(bus.PC_F)));
    chk("pred_target",  bus.PRED_TARGET_F,      m_target(bus.PC_F));
    chk("mispredict",   32'(bus.MISPREDICT_E),  32'(m_mis()));
    chk("redirect",     bus.REDIRECT_PC_E,      m_redirect());
    chk("lookup_cnt",   bus.LOOKUP_CNT,         32'(m_lcnt));
    chk("mispred_cnt",  bus.MISPRED_CNT,        32'(m_mcnt));
    chk("lookup_cnt4",  32'(bus4.LOOKUP_CNT),   32'(m_lcnt4));
    chk("mispred_cnt4", 32'(bus4.MISPRED_CNT),  32'(m_mcnt4));
    chk("pred_target4", bus4.PRED_TARGET_F,     m_target(bus.PC_F));
  endtask

  task automatic model_update();
    bit mis = m_mis();
    int s;
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m[i].valid = 1'b0;
        m[i].ctr   = 0;
      end
      m_lcnt = 0; m_mcnt = 0; m_lcnt4 = 0; m_mcnt4 = 0;
      return;
    end
    if (bus.LOOKUP_EN) begin
      if (m_lcnt  < MAX32) m_lcnt++;
      if (m_lcnt4 < MAX4)  m_lcnt4++;
    end
    if (mis) begin
      if (m_mcnt  < MAX32) m_mcnt++;
      if (m_mcnt4 < MAX4)  m_mcnt4++;
    end
    if (bus.FLUSH_ALL) begin
      for (int i = 0; i < ENTRIES; i++) m[i].valid = 1'b0;
    end else if (bus.UPD_VALID) begin
      s = slot(bus.UPD_PC);
      if (m[s].valid && m[s].word == bus.UPD_PC[31:2]) begin
        if (!bus.UPD_IS_JUMP) begin
          if (bus.UPD_TAKEN) begin
            m[s].ctr    = (m[s].ctr < 3) ? m[s].ctr + 1 : 3;
            m[s].target = bus.UPD_TARGET;
          end else begin
            m[s].ctr = (m[s].ctr > 0) ? m[s].ctr - 1 : 0;
          end
        end else begin
          m[s].ctr    = 3;
          m[s].target = bus.UPD_TARGET;
          m[s].jump   = 1'b1;
        end
      end else if (bus.UPD_TAKEN) begin
        m[s].valid  = 1'b1;
        m[s].word   = bus.UPD_PC[31:2];
        m[s].target = bus.UPD_TARGET;
        m[s].jump   = bus.UPD_IS_JUMP;
        m[s].ctr    = bus.UPD_IS_JUMP ? 3 : 2;
      end
    end
  endtask

  // Settle: let the combinational outputs stabilise, then run the full compare.
  task automatic settle();
    #1;
    compare_all();
    $display("t=%0t rst=%0b pc_f=%h pred=%0b tgt=%h upd=%0b upd_pc=%h jmp=%0b tk=%0b flush=%0b mis=%0b",
             $time, rst, bus.PC_F, bus.PRED_TAKEN_F, bus.PRED_TARGET_F, bus.UPD_VALID,
             bus.UPD_PC, bus.UPD_IS_JUMP, bus.UPD_TAKEN, bus.FLUSH_ALL, bus.MISPREDICT_E);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] pc_f);
    bus.LOOKUP_EN = 1'b0;
    bus.PC_F = pc_f;
    bus.UPD_VALID = 1'b0;
    bus.UPD_PC = 32'h0;
    bus.UPD_IS_JUMP = 1'b0;
    bus.UPD_TAKEN = 1'b0;
    bus.UPD_TARGET = 32'h0;
    bus.UPD_PRED_TAKEN = 1'b0;
    bus.UPD_PRED_TARGET = 32'h0;
    bus.FLUSH_ALL = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input bit jmp, input bit tk,
                     input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    bus.UPD_VALID = 1'b1;
    bus.UPD_PC = pc;
    bus.UPD_IS_JUMP = jmp;
    bus.UPD_TAKEN = tk;
    bus.UPD_TARGET = tgt;
    bus.UPD_PRED_TAKEN = ptk;
    bus.UPD_PRED_TARGET = ptgt;
  endtask

  // Apply one update cycle and then return the update inputs to idle.
  task automatic upd_cycle(input logic [31:0] pc, input bit jmp, input bit tk,
                           input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    idle(32'h0);
    upd(pc, jmp, tk, tgt, ptk, ptgt);
    settle();
    advance();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc, tgt;
    bit jmp, tk;

    rst = 1'b1;
    idle(32'h100);
    @(negedge clk);
    advance();
    rst = 1'b0;

    // 1. Post-reset prediction is fall-through, including the wrap at the top of memory.
    idle(32'h100); settle();
    chk("lit_rst_taken", 32'(bus.PRED_TAKEN_F), 32'h0);
    chk("lit_rst_target", bus.PRED_TARGET_F, 32'h104);
    chk("lit_rst_lcnt", bus.LOOKUP_CNT, 32'h0);
    chk("lit_rst_mcnt", bus.MISPRED_CNT, 32'h0);
    advance();
    idle(32'hFFFF_FFFC); settle();
    chk("lit_wrap_target", bus.PRED_TARGET_F, 32'h0);
    advance();

    // 2. Branch training at 0x200 -> 0x180.
    idle(32'h0); upd(32'h200, 0, 1, 32'h180, 0, 32'h0); settle();
    chk("lit_train_mis", 32'(bus.MISPREDICT_E), 32'h1);
    chk("lit_train_redir", bus.REDIRECT_PC_E, 32'h180);
    advance();
    idle(32'h200); settle();
    chk("lit_train_taken", 32'(bus.PRED_TAKEN_F), 32'h1);
    chk("lit_train_target", bus.PRED_TARGET_F, 32'h180);
    chk("lit_train_mcnt", bus.MISPRED_CNT, 32'h1);
    advance();
    upd_cycle(32'h200, 0, 0, 32'h180, 1, 32'h180);
    upd_cycle(32'h200, 0, 0, 32'h180, 1, 32'h180);
    idle(32'h200); settle();
    chk("lit_nt_taken", 32'(bus.PRED_TAKEN_F), 32'h0);
    chk("lit_nt_target", bus.PRED_TARGET_F, 32'h204);
    advance();
    for (int i = 0; i < 4; i++) upd_cycle(32'h200, 0, 1, 32'h180, 1, 32'h180);
    upd_cycle(32'h200, 0, 0, 32'h180, 1, 32'h180);
    // After saturating at 3, a single not-taken update leaves the counter at 2,
    // so the branch is still predicted taken.
    idle(32'h200); settle();
    chk("lit_sat_taken", 32'(bus.PRED_TAKEN_F), 32'h1);
    chk("lit_sat_target", bus.PRED_TARGET_F, 32'h180);
    advance();

    // 3. Aliasing: 0x240 maps to the same slot as 0x200 and replaces it.
    upd_cycle(32'h240, 0, 1, 32'h280, 0, 32'h0);
    idle(32'h200); settle();
    chk("lit_alias_old", bus.PRED_TARGET_F, 32'h204);
    advance();
    idle(32'h240); settle();
    chk("lit_alias_new", bus.PRED_TARGET_F, 32'h280);
    advance();

    // 4. A jump with a wrong predicted target retrains the stored target.
    upd_cycle(32'h300, 1, 1, 32'h400, 0, 32'h0);
    idle(32'h0); upd(32'h300, 1, 1, 32'h404, 1, 32'h500); settle();
    chk("lit_jmp_mis", 32'(bus.MISPREDICT_E), 32'h1);
    chk("lit_jmp_redir", bus.REDIRECT_PC_E, 32'h404);
    advance();
    idle(32'h300); settle();
    chk("lit_jmp_target", bus.PRED_TARGET_F, 32'h404);
    advance();

    // 5. A same-cycle update and lookup return the old contents. A flush
    //    discards the update that arrives with it.
    idle(32'h200); upd(32'h200, 0, 1, 32'h1C0, 0, 32'h0); settle();
    chk("lit_same_old", bus.PRED_TARGET_F, 32'h204);
    advance();
    idle(32'h200); settle();
    chk("lit_same_new", bus.PRED_TARGET_F, 32'h1C0);
    advance();
    idle(32'h0); upd(32'h300, 1, 1, 32'h400, 0, 32'h0); bus.FLUSH_ALL = 1'b1; settle(); advance();
    idle(32'h300); settle();
    chk("lit_flush_300", bus.PRED_TARGET_F, 32'h304);
    advance();
    idle(32'h200); settle();
    chk("lit_flush_200", bus.PRED_TARGET_F, 32'h204);
    advance();

    // 6. The 4-bit lookup counter saturates. A reset that arrives during an
    //    update wins over the update.
    rst = 1'b1; idle(32'h0); settle(); advance(); rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      idle(32'h100); bus.LOOKUP_EN = 1'b1; settle(); advance();
    end
    idle(32'h100); settle();
    chk("lit_lcnt4_sat", 32'(bus4.LOOKUP_CNT), 32'd15);
    chk("lit_lcnt32", bus.LOOKUP_CNT, 32'd20);
    advance();
    rst = 1'b1; idle(32'h0); bus.LOOKUP_EN = 1'b1; upd(32'h500, 0, 1, 32'h600, 0, 32'h0);
    settle(); advance(); rst = 1'b0;
    idle(32'h500); settle();
    chk("lit_rstupd_taken", 32'(bus.PRED_TAKEN_F), 32'h0);
    chk("lit_rstupd_target", bus.PRED_TARGET_F, 32'h504);
    chk("lit_rstupd_lcnt", bus.LOOKUP_CNT, 32'h0);
    chk("lit_rstupd_mcnt", bus.MISPRED_CNT, 32'h0);
    advance();

    // Randomized phase. PCs are drawn from a small pool so that hits and
    // aliasing are frequent. Whether a PC is a jump depends only on the PC.
    for (int n = 0; n < 3000; n++) begin
      idle(32'h1000 + ($urandom_range(0, 47) << 2) + $urandom_range(0, 3));
      bus.LOOKUP_EN = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) < 6) begin
        pc  = 32'h1000 + ($urandom_range(0, 47) << 2) + $urandom_range(0, 3);
        jmp = (((pc >> 2) % 5) == 0);
        tk  = jmp ? 1'b1 : 1'($urandom_range(0, 1));
        tgt = 32'h2000 + ($urandom_range(0, 7) << 2);
        upd(pc, jmp, tk, tgt, m_taken(pc), m_target(pc));
        if ($urandom_range(0, 3) == 0) bus.UPD_PRED_TAKEN = ~bus.UPD_PRED_TAKEN;
        if ($urandom_range(0, 3) == 0) bus.UPD_PRED_TARGET = tgt;
      end
      bus.FLUSH_ALL = ($urandom_range(0, 79) == 0);
      settle();
      advance();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
